waveform_buffer_reader: RTL and testbench

//  Drains waveform_buffer_storage one event at a time: pops a header from the header FIFO,

---
 rtl/waveform_buffer_reader.sv | 207 ++++++++++++++++++++
 tb/tb_waveform_buffer_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_buffer_reader.sv
// Drains one event at a time from the header FIFO and waveform RAM into a
// valid/ready word stream: header slices first, then samples up to the EOE bit.
module waveform_buffer_reader #(
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_START_LSB  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_is_hdr,
  output logic                    out_last,
  output logic [P_ADR_WIDTH-1:0]  rd_ptr,
  output logic                    evt_done,
  output logic [15:0]             n_evt_read,
  output logic                    overrun_err,
  output logic                    busy
);

  localparam int unsigned N_HW      = (P_HDR_WIDTH + P_DATA_WIDTH - 1) / P_DATA_WIDTH;
  localparam int unsigned HDR_PAD_W = N_HW * P_DATA_WIDTH;
  localparam int unsigned HCNT_W    = $clog2(N_HW + 1);
  localparam int unsigned HBASE_W   = $clog2(HDR_PAD_W + 1);
  localparam int unsigned SPAN_W    = P_ADR_WIDTH + 1;
  localparam logic [SPAN_W-1:0] SPAN = {1'b1, {P_ADR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_HDR, S_SAMP} state_t;

  state_t                  state, state_nx;
  logic [P_HDR_WIDTH-1:0]  hdr_reg;
  logic [HDR_PAD_W-1:0]    hdr_pad;
  logic [HBASE_W-1:0]      hdr_base;
  logic [HCNT_W-1:0]       hdr_push_cnt, hdr_pop_cnt;
  logic [SPAN_W-1:0]       iss_cnt;
  logic [P_ADR_WIDTH-1:0]  ret_cnt, ret_addr, ptr_pend;
  logic                    ret_q, eoe_seen;
  logic                    skid_valid, skid_is_hdr, skid_last;
  logic [P_DATA_WIDTH-1:0] skid_data;

  logic                    pop, issue, ret_v, ret_last, done;
  logic                    push, push_is_hdr, push_last;
  logic [P_DATA_WIDTH-1:0] push_data;
  logic [1:0]              occ_after;

  assign hdr_pad  = HDR_PAD_W'(hdr_reg);
  assign hdr_base = HBASE_W'(hdr_push_cnt * P_DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state, output-stage push selection and read-issue throttling
  always_comb begin
    state_nx    = state;
    pop         = out_valid & out_ready;
    ret_v       = ret_q & ~eoe_seen & (state == S_SAMP);
    ret_last    = ret_v & (wvb_data[0] | (ret_cnt == '1));
    occ_after   = 2'(out_valid) + 2'(skid_valid) - 2'(pop);
    done        = (state == S_SAMP) & pop & out_last;
    issue       = 1'b0;
    push        = 1'b0;
    push_is_hdr = 1'b0;
    push_last   = 1'b0;
    push_data   = '0;
    case (state)
      S_IDLE:  if (!hdr_empty) state_nx = S_POP;
      S_POP:   state_nx = S_LATCH;
      S_LATCH: state_nx = S_HDR;
      S_HDR: begin
        if (!skid_valid && (hdr_push_cnt < HCNT_W'(N_HW))) begin
          push        = 1'b1;
          push_is_hdr = 1'b1;
          push_data   = P_DATA_WIDTH'(hdr_pad >> hdr_base);
        end
        if (pop && (hdr_pop_cnt == HCNT_W'(N_HW - 1))) state_nx = S_SAMP;
      end
      S_SAMP: begin
        // occupancy counted after this cycle's pop keeps 1 word/cycle at full ready
        issue     = ~eoe_seen & ~ret_last & (iss_cnt != SPAN) &
                    ((occ_after + 2'(ret_v)) < 2'd2);
        push      = ret_v;
        push_data = wvb_data;
        push_last = ret_last;
        if (done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_rdreq    <= 1'b0;
      busy         <= 1'b0;
      evt_done     <= 1'b0;
      hdr_reg      <= '0;
      wvb_rd_addr  <= '0;
      hdr_push_cnt <= '0;
      hdr_pop_cnt  <= '0;
      iss_cnt      <= '0;
      ret_cnt      <= '0;
      ret_addr     <= '0;
      ptr_pend     <= '0;
      ret_q        <= 1'b0;
      eoe_seen     <= 1'b0;
      rd_ptr       <= '0;
      n_evt_read   <= '0;
      overrun_err  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_is_hdr   <= 1'b0;
      out_last     <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_is_hdr  <= 1'b0;
      skid_last    <= 1'b0;
    end else begin
      hdr_rdreq <= (state == S_IDLE) && (state_nx == S_POP);
      busy      <= (state_nx != S_IDLE);
      evt_done  <= done;
      ret_q     <= issue;

      if (state == S_LATCH) begin
        hdr_reg      <= hdr_data;
        wvb_rd_addr  <= hdr_data[P_START_LSB +: P_ADR_WIDTH];
        hdr_push_cnt <= '0;
        hdr_pop_cnt  <= '0;
        iss_cnt      <= '0;
        ret_cnt      <= '0;
        eoe_seen     <= 1'b0;
      end

      if (state == S_HDR && push) hdr_push_cnt <= hdr_push_cnt + HCNT_W'(1);
      if (state == S_HDR && pop)  hdr_pop_cnt  <= hdr_pop_cnt + HCNT_W'(1);

      if (issue) begin
        ret_addr    <= wvb_rd_addr;
        wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
        iss_cnt     <= iss_cnt + SPAN_W'(1);
      end
      if (ret_v) ret_cnt <= ret_cnt + P_ADR_WIDTH'(1);

      // A forced last without EOE means the whole RAM span was consumed
      if (ret_last) begin
        eoe_seen <= 1'b1;
        ptr_pend <= ret_addr + P_ADR_WIDTH'(1);
        if (!wvb_data[0]) overrun_err <= 1'b1;
      end

      if (done) begin
        rd_ptr     <= ptr_pend;
        n_evt_read <= n_evt_read + 16'd1;
      end

      // Output register plus one skid entry
      case ({pop, push})
        2'b11: begin
          if (skid_valid) begin
            out_data    <= skid_data;
            out_is_hdr  <= skid_is_hdr;
            out_last    <= skid_last;
            skid_data   <= push_data;
            skid_is_hdr <= push_is_hdr;
            skid_last   <= push_last;
          end else begin
            out_data   <= push_data;
            out_is_hdr <= push_is_hdr;
            out_last   <= push_last;
          end
        end
        2'b10: begin
          if (skid_valid) begin
            out_data   <= skid_data;
            out_is_hdr <= skid_is_hdr;
            out_last   <= skid_last;
            skid_valid <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b01: begin
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_data   <= push_data;
            out_is_hdr <= push_is_hdr;
            out_last   <= push_last;
          end else begin
            skid_valid  <= 1'b1;
            skid_data   <= push_data;
            skid_is_hdr <= push_is_hdr;
            skid_last   <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Bench for waveform_buffer_reader: header FIFO and RAM models, a scoreboard of
// expected output words, a table of single-event vectors and multi-cycle corner cases.
module tb_waveform_buffer_reader;

  typedef struct packed {
    logic        is_hdr;
    logic        last;
    logic [21:0] data;
  } word_t;

  typedef struct {
    logic [11:0] start;
    int          nsamp;
    int          pct;
    logic [11:0] exp_ptr;
    logic [15:0] exp_nevt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        hdr_empty = 1'b1;
  logic [79:0] hdr_data  = '0;
  logic        hdr_rdreq;
  logic [11:0] wvb_rd_addr;
  logic [21:0] wvb_data  = '0;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_data;
  logic        out_is_hdr;
  logic        out_last;
  logic [11:0] rd_ptr;
  logic        evt_done;
  logic [15:0] n_evt_read;
  logic        overrun_err;
  logic        busy;

  waveform_buffer_reader dut (
    .clk(clk), .rst(rst), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_hdr(out_is_hdr), .out_last(out_last), .rd_ptr(rd_ptr),
    .evt_done(evt_done), .n_evt_read(n_evt_read), .overrun_err(overrun_err),
    .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          ready_pct = 100;
  int          cyc = 0, done_cyc = 0;
  int          evt_cnt = 0, rdreq_cnt = 0, samp_cnt = 0;
  bit          samp_seen = 0, gap_en = 0, gap_arm = 0, prev_stall = 0;
  logic [23:0] held;
  word_t       exp_q[$];
  logic [79:0] hq[$];
  logic [21:0] mem [0:4095];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Header FIFO and waveform RAM models
  always @(posedge clk) begin
    if (hdr_rdreq && hq.size() > 0) hdr_data <= hq.pop_front();
    hdr_empty <= (hq.size() == 0);
    wvb_data  <= mem[wvb_rd_addr];
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, protocol rules
  always @(negedge clk) begin
    cyc++;
    if (!gap_en) gap_arm = 0;
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (hdr_rdreq) begin
        rdreq_cnt++;
        chk("rdreq_while_empty", 32'(hdr_empty), 32'd0);
        if (gap_arm) begin
          chk("event_gap_le2", 32'(cyc - done_cyc <= 2), 32'd1);
          gap_arm = 0;
        end
      end
      if (evt_done) begin
        evt_cnt++;
        done_cyc = cyc;
        gap_arm  = gap_en;
      end
      if (prev_stall)
        chk("stall_hold", 32'({out_valid, out_is_hdr, out_last, out_data}), 32'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", {out_is_hdr, out_last, out_data});
        end else begin
          chk("out_word", 32'({out_is_hdr, out_last, out_data}), 32'(exp_q.pop_front()));
        end
        if (!out_is_hdr) begin
          samp_cnt++;
          samp_seen = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_is_hdr, out_last, out_data};
    end
  end

  function automatic logic [21:0] samp_val(input int i, input int n, input bit eoe);
    return 22'((i + 1) << 8) | 22'(eoe && (i == n - 1));
  endfunction

  function automatic logic [79:0] make_hdr(input logic [11:0] s);
    logic [79:0] h;
    h = {16'($urandom), $urandom, $urandom};
    h[11:0] = s;
    return h;
  endfunction

  task automatic load_event(input logic [79:0] h, input logic [11:0] s, input int n, input bit eoe);
    for (int i = 0; i < n; i++) mem[12'(s + 12'(i))] = samp_val(i, n, eoe);
    hq.push_back(h);
  endtask

  task automatic push_exp(input logic [79:0] h, input int n, input bit eoe);
    logic [87:0] pad;
    word_t       w;
    pad = {8'h00, h};
    for (int k = 0; k < 4; k++) begin
      w.is_hdr = 1'b1;
      w.last   = 1'b0;
      w.data   = pad[k*22 +: 22];
      exp_q.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      w.is_hdr = 1'b0;
      w.last   = (i == n - 1);
      w.data   = samp_val(i, n, eoe);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_events(input int target, input int budget);
    int n = 0;
    while (evt_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("evt_count_reached", 32'(evt_cnt), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [79:0] h;
    int          e0;
    ready_pct = v.pct;
    h  = make_hdr(v.start);
    e0 = evt_cnt;
    load_event(h, v.start, v.nsamp, 1'b1);
    push_exp(h, v.nsamp, 1'b1);
    wait_events(e0 + 1, 2000);
    repeat (2) @(negedge clk);
    chk("vec_rd_ptr", 32'(rd_ptr), 32'(v.exp_ptr));
    chk("vec_n_evt_read", 32'(n_evt_read), 32'(v.exp_nevt));
    chk("vec_busy_idle", 32'(busy), 32'd0);
    chk("vec_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("vec_no_overrun", 32'(overrun_err), 32'd0);
  endtask

  vec_t        vecs[5];
  logic [79:0] h, ha, hb;
  int          r0, e0, s0, n;

  initial begin
    rst = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hdr_rdreq", 32'(hdr_rdreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt_done", 32'(evt_done), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_n_evt_read", 32'(n_evt_read), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_wvb_rd_addr", 32'(wvb_rd_addr), 32'd0);
    rst = 1'b1;

    // basic, wrap, backpressure, single sample, longer event at half duty
    vecs[0] = '{12'h010, 4,  100, 12'h014, 16'd1};
    vecs[1] = '{12'hFFE, 4,  100, 12'h002, 16'd2};
    vecs[2] = '{12'h010, 4,  30,  12'h014, 16'd3};
    vecs[3] = '{12'h123, 1,  100, 12'h124, 16'd4};
    vecs[4] = '{12'h800, 20, 50,  12'h814, 16'd5};
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // back-to-back single-sample events
    do_reset();
    ready_pct = 100;
    r0 = rdreq_cnt;
    e0 = evt_cnt;
    gap_en = 1;
    for (int k = 0; k < 3; k++) begin
      h = make_hdr(12'(12'h200 + k * 12'h100));
      load_event(h, 12'(12'h200 + k * 12'h100), 1, 1'b1);
      push_exp(h, 1, 1'b1);
    end
    wait_events(e0 + 3, 300);
    repeat (3) @(negedge clk);
    chk("b2b_rdreq_pulses", 32'(rdreq_cnt - r0), 32'd3);
    chk("b2b_evt_done_pulses", 32'(evt_cnt - e0), 32'd3);
    chk("b2b_n_evt_read", 32'(n_evt_read), 32'd3);
    chk("b2b_rd_ptr", 32'(rd_ptr), 32'h401);
    chk("b2b_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    gap_en = 0;

    // overrun: no EOE anywhere in RAM
    do_reset();
    s0 = samp_cnt;
    e0 = evt_cnt;
    h  = make_hdr(12'h100);
    load_event(h, 12'h100, 4096, 1'b0);
    push_exp(h, 4096, 1'b0);
    wait_events(e0 + 1, 10000);
    repeat (2) @(negedge clk);
    chk("ovr_sample_words", 32'(samp_cnt - s0), 32'd4096);
    chk("ovr_overrun_err", 32'(overrun_err), 32'd1);
    chk("ovr_n_evt_read", 32'(n_evt_read), 32'd1);
    chk("ovr_rd_ptr", 32'(rd_ptr), 32'h100);
    chk("ovr_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // reset during sample streaming, then the next queued header
    ready_pct = 30;
    ha = make_hdr(12'h050);
    hb = make_hdr(12'h600);
    load_event(ha, 12'h050, 30, 1'b1);
    push_exp(ha, 30, 1'b1);
    load_event(hb, 12'h600, 5, 1'b1);
    samp_seen = 0;
    n = 0;
    while (!samp_seen && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("mid_samples_started", 32'(samp_seen), 32'd1);
    #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_n_evt_read", 32'(n_evt_read), 32'd0);
    chk("mid_rst_overrun", 32'(overrun_err), 32'd0);
    chk("mid_rst_hdr_rdreq", 32'(hdr_rdreq), 32'd0);
    rst = 1'b1;
    push_exp(hb, 5, 1'b1);
    ready_pct = 100;
    e0 = evt_cnt;
    wait_events(e0 + 1, 500);
    repeat (2) @(negedge clk);
    chk("mid_next_rd_ptr", 32'(rd_ptr), 32'h605);
    chk("mid_next_n_evt_read", 32'(n_evt_read), 32'd1);
    chk("mid_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
